// File: rtl/rc4_pkg.sv
// Shared definitions for the rc4 keystream XOR stage: default widths,
// FSM state encodings and a ceil-log2 helper for pointer sizing.
package rc4_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Small synchronous FIFO holding keystream bytes so the generator can run
// ahead of plaintext; pointers carry an extra wrap bit for full/empty.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// Keystream XOR stage: buffers rc4 keystream, XORs it with plaintext and
// emits exactly msg_len ciphertext bytes per transaction, then pulses done.
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic [DATA_W-1:0] ks_byte,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [DATA_W-1:0] pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [DATA_W-1:0] ct_data,
  output logic              ct_valid,
  input  logic              ct_ready,
  output logic              ct_last,
  output logic              busy,
  output logic              done
);

  logic [1:0]        state;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  ks_cnt;
  logic [LEN_W-1:0]  pt_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ks_fire;
  logic              pt_fire;
  logic              ct_fire;

  assign ks_ready = (state == ST_RUN) && !fifo_full && (ks_cnt < len);
  assign pt_ready = (state == ST_RUN) && !fifo_empty && (pt_cnt < len) &&
                    (!ct_valid || ct_ready);
  assign ks_fire  = ks_valid && ks_ready;
  assign pt_fire  = pt_valid && pt_ready;
  assign ct_fire  = ct_valid && ct_ready;
  assign busy     = (state == ST_RUN) || (state == ST_DONE);
  assign done     = (state == ST_DONE);

  // Clearing during DONE discards any keystream fetched beyond what was used.
  rc4_ks_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ks_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == ST_DONE),
    .push      (ks_fire),
    .push_data (ks_byte),
    .pop       (pt_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      len    <= '0;
      ks_cnt <= '0;
      pt_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len    <= msg_len;
            ks_cnt <= '0;
            pt_cnt <= '0;
            state  <= (msg_len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (ks_fire) ks_cnt <= ks_cnt + LEN_W'(1);
          if (pt_fire) pt_cnt <= pt_cnt + LEN_W'(1);
          if (ct_fire && ct_last) state <= ST_DONE;
        end
        ST_DONE: begin
          ks_cnt <= '0;
          pt_cnt <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new byte may replace the current one in the same cycle it is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ct_data  <= '0;
      ct_valid <= 1'b0;
      ct_last  <= 1'b0;
    end else if (pt_fire) begin
      ct_data  <= pt_data ^ fifo_head;
      ct_valid <= 1'b1;
      ct_last  <= (pt_cnt == len - LEN_W'(1));
    end else if (ct_fire) begin
      ct_valid <= 1'b0;
      ct_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed bench for rc4_xor_stream: known-answer vectors, stalls,
// zero-length, reset abort and ignored restart, checked by immediate asserts.
module tb_rc4_xor_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] msg_len;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  pt_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  ct_data;
  logic        ct_valid;
  logic        ct_ready;
  logic        ct_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ks_vec[$];
  logic [7:0] pt_vec[$];
  logic [7:0] exp_vec[$];
  int pt_gap_after;
  int pt_gap_len;
  int stall_at;
  int stall_len;
  int abort_after;
  int restart_at;
  bit check_full;

  always #5 clk = ~clk;

  rc4_xor_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .msg_len  (msg_len),
    .ks_byte  (ks_byte),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .pt_data  (pt_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .ct_data  (ct_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .ct_last  (ct_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_defaults();
    pt_gap_after = -1;
    pt_gap_len   = 0;
    stall_at     = 1000;
    stall_len    = 0;
    abort_after  = -1;
    restart_at   = -1;
    check_full   = 1'b0;
  endtask

  task automatic start_txn(input logic [15:0] len);
    start   = 1'b1;
    msg_len = len;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_output("start_busy", busy, 1);
  endtask

  // Drives keystream/plaintext from the vectors and checks each ciphertext byte.
  task automatic apply_stimulus(input int n, input int max_cycles);
    int ki = 0;
    int pi = 0;
    int ci = 0;
    int cyc = 0;
    int gap = 0;
    bit held_ok = 1'b0;
    logic [7:0] held = 8'h00;
    while (ci < n && ci != abort_after && cyc < max_cycles) begin
      ks_valid = (ki < ks_vec.size());
      ks_byte  = ks_valid ? ks_vec[ki] : 8'h00;
      pt_valid = (pi < n) && (gap == 0);
      pt_data  = pt_valid ? pt_vec[pi] : 8'h00;
      ct_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      start    = (cyc == restart_at);
      if (cyc == restart_at) msg_len = 16'd5;
      #1;
      check_output("done_low_in_run", done, 0);
      if (ki >= n) check_output("ks_ready_capped", ks_ready, 0);
      if (!ct_ready && held_ok) begin
        check_output("hold_valid", ct_valid, 1);
        check_output("hold_data", ct_data, held);
        check_output("stall_pt_ready", pt_ready, 0);
      end else if (!ct_ready && ct_valid) begin
        held    = ct_data;
        held_ok = 1'b1;
        check_output("stall_pt_ready", pt_ready, 0);
      end
      if (check_full && cyc == stall_at + stall_len - 1)
        check_output("full_ks_ready", ks_ready, 0);
      if (ct_valid && ct_ready) begin
        check_output($sformatf("ct_data[%0d]", ci), ct_data, exp_vec[ci]);
        check_output($sformatf("ct_last[%0d]", ci), ct_last, (ci == n - 1));
        ci++;
      end
      if (pt_valid && pt_ready) begin
        pi++;
        if (pi == pt_gap_after) gap = pt_gap_len;
      end else if (gap > 0) begin
        gap--;
      end
      if (ks_valid && ks_ready) ki++;
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    ks_valid = 1'b0;
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    #1;
    if (ci == abort_after) return;
    check_output("ct_count", ci, n);
    check_output("ks_count", ki, n);
    check_output("pt_count", pi, n);
    check_output("done_pulse", done, 1);
    check_output("done_busy", busy, 1);
    @(negedge clk);
    #1;
    check_output("done_cleared", done, 0);
    check_output("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    msg_len  = 16'd0;
    ks_byte  = 8'h00;
    ks_valid = 1'b0;
    pt_data  = 8'h00;
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    set_defaults();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("rst_ct_data", ct_data, 0);
    check_output("rst_ct_valid", ct_valid, 0);
    check_output("rst_ct_last", ct_last, 0);
    check_output("rst_ks_ready", ks_ready, 0);
    check_output("rst_pt_ready", pt_ready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] known-answer Key/Plaintext");
    ks_vec  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    pt_vec  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    exp_vec = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    start_txn(16'd9);
    apply_stimulus(9, 100);

    $display("[TB] early keystream, late plaintext");
    set_defaults();
    pt_gap_after = 1;
    pt_gap_len   = 5;
    ks_vec  = '{8'hA5, 8'h00, 8'hFF};
    pt_vec  = '{8'h3C, 8'h11};
    exp_vec = '{8'h99, 8'h11};
    start_txn(16'd2);
    apply_stimulus(2, 100);

    $display("[TB] downstream backpressure");
    set_defaults();
    stall_at   = 2;
    stall_len  = 4;
    check_full = 1'b1;
    ks_vec  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    pt_vec  = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    exp_vec = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
    start_txn(16'd8);
    apply_stimulus(8, 100);

    $display("[TB] zero-length transaction");
    ks_valid = 1'b1;
    pt_valid = 1'b1;
    start_txn(16'd0);
    check_output("zero_done", done, 1);
    check_output("zero_ks_ready", ks_ready, 0);
    check_output("zero_pt_ready", pt_ready, 0);
    @(negedge clk);
    #1;
    check_output("zero_done_clear", done, 0);
    check_output("zero_idle_busy", busy, 0);
    ks_valid = 1'b0;
    pt_valid = 1'b0;

    $display("[TB] reset mid-transaction");
    set_defaults();
    abort_after = 3;
    ks_vec  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pt_vec  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    exp_vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    start_txn(16'd8);
    apply_stimulus(8, 100);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_output("abort_ct_valid", ct_valid, 0);
    check_output("abort_ct_data", ct_data, 0);
    check_output("abort_ct_last", ct_last, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_output("abort_no_done", done, 0);
    set_defaults();
    ks_vec  = '{8'h01, 8'h02, 8'h03};
    pt_vec  = '{8'h10, 8'h20, 8'h30};
    exp_vec = '{8'h11, 8'h22, 8'h33};
    start_txn(16'd3);
    apply_stimulus(3, 100);

    $display("[TB] start ignored while running");
    set_defaults();
    restart_at = 3;
    ks_vec  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    pt_vec  = '{8'hFF, 8'hFF, 8'h00, 8'h0F};
    exp_vec = '{8'hED, 8'hCB, 8'h56, 8'h77};
    start_txn(16'd4);
    apply_stimulus(4, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
